// File: rtl/keypad_if.sv
// Keypad matrix bundle: column returns in, row drives and debounced key status out.
// master = scanner side, slave = consumer/matrix side.
interface keypad_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int KEY_W = 5
);
    logic [COLS-1:0]  columna;
    logic [ROWS-1:0]  fila;
    logic [KEY_W-1:0] key;
    logic             keypad_pressed;
    logic             key_held;

    modport master (
        input  columna,
        output fila,
        output key,
        output keypad_pressed,
        output key_held
    );

    modport slave (
        output columna,
        input  fila,
        input  key,
        input  keypad_pressed,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner_n.sv
// ROWS x COLS keypad scanner with synchroniser, debounce, press strobe and held level.
// Optional typematic auto-repeat enabled by defining KEYPAD_TYPEMATIC_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_SCAN    | drive rows in turn, sample columns at end of each slot
// S_DEBOUNCE| pattern seen on current row, waiting for it to stay stable
// S_HELD    | key accepted, row frozen, waiting for all columns high
// S_RELEASE | all columns high, waiting for release to stay stable
module keypad_scanner_n #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int KEY_W         = 5,
    parameter int SCAN_DIV      = 50000,
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic      clk,
    input  logic      rst_n,
    keypad_if.master  kp
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYC);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

    localparam bit CFG_OK = (ROWS >= 2) && (ROWS <= 8) && (COLS >= 2) && (COLS <= 8) &&
                            (ROWS * COLS <= (1 << KEY_W)) && (SCAN_DIV >= 4) &&
                            (DEBOUNCE_CYC >= 2) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

    if (!CFG_OK) begin : g_bad_cfg
        $error("keypad_scanner_n: illegal parameter combination");
    end

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [1:0]        state;
    logic [COLS-1:0]   sync1;
    logic [COLS-1:0]   col_s;
    logic [COLS-1:0]   pattern;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_next;
    logic [SLOT_W-1:0] slot_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [KEY_W-1:0]  key_r;
    logic [KEY_W-1:0]  key_code;
    logic              pressed_r;
    logic              held_r;
    logic              col_idle;

    // Lowest-numbered active (zero) column wins on a multi-press.
    function automatic logic [COL_W-1:0] lowest_zero(input logic [COLS-1:0] p);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!p[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction

    assign col_idle = &col_s;
    assign row_next = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    assign key_code = KEY_W'(row) * KEY_W'(COLS) + KEY_W'(lowest_zero(pattern));

    assign kp.fila           = ~(ROWS'(1) << row);
    assign kp.key            = key_r;
    assign kp.keypad_pressed = pressed_r;
    assign kp.key_held       = held_r;

`ifdef KEYPAD_TYPEMATIC_EN
    localparam logic [31:0] REP_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] REP_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rep_cnt;
    logic        rep_first;
    logic        rep_hit;

    assign rep_hit = (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_SCAN;
            sync1     <= '1;
            col_s     <= '1;
            pattern   <= '1;
            row       <= '0;
            slot_cnt  <= '0;
            deb_cnt   <= '0;
            key_r     <= '0;
            pressed_r <= 1'b0;
            held_r    <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            sync1     <= kp.columna;
            col_s     <= sync1;
            pressed_r <= 1'b0;
            case (state)
                S_SCAN: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (col_idle) begin
                            row <= row_next;
                        end else begin
                            pattern <= col_s;
                            deb_cnt <= '0;
                            state   <= S_DEBOUNCE;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (col_s == pattern) begin
                        if (deb_cnt == DEB_LAST) begin
                            state     <= S_HELD;
                            key_r     <= key_code;
                            pressed_r <= 1'b1;
                            held_r    <= 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
`endif
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else if (col_idle) begin
                        // Bounce: give up on this row without a strobe.
                        state    <= S_SCAN;
                        row      <= row_next;
                        slot_cnt <= '0;
                    end else begin
                        pattern <= col_s;
                        deb_cnt <= '0;
                    end
                end
                S_HELD: begin
                    if (col_idle) begin
                        state   <= S_RELEASE;
                        deb_cnt <= '0;
                    end
`ifdef KEYPAD_TYPEMATIC_EN
                    else if (rep_hit) begin
                        pressed_r <= 1'b1;
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 32'd1;
                    end
`endif
                end
                S_RELEASE: begin
                    if (!col_idle) begin
                        state   <= S_HELD;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= S_SCAN;
                        held_r   <= 1'b0;
                        row      <= row_next;
                        slot_cnt <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner_n.sv
// Directed bench for keypad_scanner_n (4x4, SCAN_DIV=4, DEBOUNCE_CYC=8) with a simple matrix model.
// Build with KEYPAD_TYPEMATIC_EN defined to also exercise auto-repeat (delay 20, period 10).
module tb_keypad_scanner_n;
    logic        clk;
    logic        rst_n;
    logic [15:0] keys_down;
    int          checks;
    int          passes;
    int          strobes;
    int          n;
    int          s0;
    logic [63:0] rep_map;
    logic [63:0] rep_exp;

    keypad_if #(.ROWS(4), .COLS(4), .KEY_W(5)) kp ();

    keypad_scanner_n #(
        .ROWS(4), .COLS(4), .KEY_W(5),
        .SCAN_DIV(4), .DEBOUNCE_CYC(8),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        logic [3:0] cols;
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !kp.fila[r]) cols[c] = 1'b0;
        kp.columna = cols;
    end

    always @(posedge clk) begin
        #1;
        if (kp.keypad_pressed === 1'b1) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_strobe(input int lim, output int cnt);
        cnt = 0;
        while (kp.keypad_pressed !== 1'b1 && cnt < lim) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_release(input int lim, output int cnt);
        cnt = 0;
        while (kp.key_held === 1'b1 && cnt < lim) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; passes = 0; strobes = 0;
        rst_n = 1'b0;
        keys_down = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_fila", kp.fila, 4'b1110);
        check("rst_key", kp.key, 0);
        check("rst_pressed", kp.keypad_pressed, 0);
        check("rst_held", kp.key_held, 0);

        // Row 2 col 1 held from reset release: 2 rows of scan, row 2 slot, sync, 8 debounce.
        keys_down[9] = 1'b1;
        rst_n = 1'b1;
        wait_strobe(60, n);
        check("press_latency", n, 20);
        check("press_key", kp.key, 9);
        check("press_held", kp.key_held, 1);
        check("press_fila", kp.fila, 4'b1011);
        s0 = strobes;
        @(negedge clk);
        check("strobe_width", kp.keypad_pressed, 0);
        rep_map = '0;
        for (int i = 2; i <= 55; i++) begin
            @(negedge clk);
            if (kp.keypad_pressed === 1'b1) rep_map[i] = 1'b1;
        end
`ifdef KEYPAD_TYPEMATIC_EN
        rep_exp = (64'd1 << 20) | (64'd1 << 30) | (64'd1 << 40) | (64'd1 << 50);
`else
        rep_exp = 64'd0;
`endif
        check("repeat_map_lo", rep_map[31:0], rep_exp[31:0]);
        check("repeat_map_hi", rep_map[63:32], rep_exp[63:32]);
        check("held_fila_frozen", kp.fila, 4'b1011);

        // Release: 2 sync + 1 detect + 8 stable cycles.
        s0 = strobes;
        keys_down = 16'h0000;
        wait_release(50, n);
        check("release_latency", n, 11);
        check("release_fila", kp.fila, 4'b0111);
        check("release_key", kp.key, 9);
        check("release_no_strobe", strobes, s0);

        // Bounce: column 0 low on every row for 5 cycles, three times.
        s0 = strobes;
        for (int b = 0; b < 3; b++) begin
            keys_down = 16'h1111;
            repeat (5) @(negedge clk);
            keys_down = 16'h0000;
            repeat (5) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("bounce_strobes", strobes, s0);
        check("bounce_held", kp.key_held, 0);
        n = 0;
        while (kp.fila !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bounce_scan_resume", kp.fila, 4'b1110);

        // Multi-press on row 0, columns 1 and 3.
        s0 = strobes;
        keys_down = 16'h000A;
        wait_strobe(80, n);
        check("multi_strobe", kp.keypad_pressed, 1);
        check("multi_key", kp.key, 1);
        repeat (3) @(negedge clk);
        check("multi_single", strobes, s0 + 1);
        keys_down = 16'h0000;
        wait_release(50, n);
        check("multi_released", kp.key_held, 0);
        check("multi_key_kept", kp.key, 1);

        // Reset while held, key still down: full rescan and debounce before a new strobe.
        keys_down = 16'h0200;
        wait_strobe(80, n);
        check("pre_reset_key", kp.key, 9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_fila", kp.fila, 4'b1110);
        check("mid_rst_key", kp.key, 0);
        check("mid_rst_pressed", kp.keypad_pressed, 0);
        check("mid_rst_held", kp.key_held, 0);
        wait_strobe(60, n);
        check("post_rst_latency", n, 20);
        check("post_rst_key", kp.key, 9);
        check("post_rst_held", kp.key_held, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
